hdmi_audio_sampler: RTL

- Sits directly downstream of the HDMI audio sample-rate strobe generator and upstream of the HDMI audio data-island packetizer.
- On each sample strobe, captures the stereo PCM pair and builds IEC 60958 subframe metadata for it: B (block start), C (channel status) and per-channel even parity.
- Buffers complete frames in a small show-ahead FIFO and presents them to the packetizer over a valid/ready handshake.
- Isolates the free-running strobe from packetizer back-pressure during video active periods.

---
 rtl/hdmi_audio_sampler.sv | 119 +++++++++++
 1 files changed

// File: rtl/hdmi_audio_sampler.sv
// ----------------------------------------------------------------------------
// hdmi_audio_sampler : captures stereo PCM on each strobe, adds IEC 60958 B/C/parity, show-ahead FIFO to packetizer.
// Optional mute input via AUDIO_SAMPLER_MUTE_EN.            Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hdmi_audio_sampler #(
  parameter int          DEPTH    = 4,
  parameter int          SAMPLE_W = 16,
  parameter logic [3:0]  FS_CODE  = 4'b1110
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        audio_stb,
  input  logic [SAMPLE_W-1:0]         audio_l,
  input  logic [SAMPLE_W-1:0]         audio_r,
`ifdef AUDIO_SAMPLER_MUTE_EN
  input  logic                        mute,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [23:0]                 out_l,
  output logic [23:0]                 out_r,
  output logic                        out_b,
  output logic                        out_c,
  output logic                        out_pl,
  output logic                        out_pr,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int             AW         = $clog2(DEPTH);
  localparam int             LW         = AW + 1;
  localparam int             FW         = 52;
  localparam logic [LW-1:0]  C_FULL     = LW'(DEPTH);
  localparam logic [7:0]     C_LAST_IDX = 8'd191;

  logic [FW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    fidx_q, fidx_d;
  logic [FW-1:0] head_q, head_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          w_pop, w_wr, w_full, w_mute, w_c;
  logic [23:0]   w_l24, w_r24;
  logic [FW-1:0] w_entry;

`ifdef AUDIO_SAMPLER_MUTE_EN
  assign w_mute = mute;
`else
  assign w_mute = 1'b0;
`endif

  assign w_full = (level_q == C_FULL);
  assign w_pop  = valid_q & out_ready;
  assign w_wr   = audio_stb & (~w_full | w_pop);

  assign w_l24  = w_mute ? 24'd0 : (24'(audio_l) << (24 - SAMPLE_W));
  assign w_r24  = w_mute ? 24'd0 : (24'(audio_r) << (24 - SAMPLE_W));

  // Channel status: bit 2 (copy permitted) and bits 24..27 carry FS_CODE.
  assign w_c     = (fidx_q == 8'd2) | ((fidx_q[7:2] == 6'd6) & FS_CODE[fidx_q[1:0]]);
  assign w_entry = {w_l24, w_r24, (fidx_q == 8'd0), w_c, ^{w_l24, w_c}, ^{w_r24, w_c}};

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(w_wr);
    rd_ptr_d = rd_ptr_q + AW'(w_pop);
    level_d  = level_q + LW'(w_wr) - LW'(w_pop);
    fidx_d   = fidx_q;
    if (w_wr) begin
      fidx_d = (fidx_q == C_LAST_IDX) ? 8'd0 : fidx_q + 8'd1;
    end
    valid_d  = (level_d != '0);
    ovf_d    = audio_stb & ~w_wr;
    // Head register preloads the entry that becomes head after this edge,
    // bypassing the array when that entry is being written right now.
    head_d   = head_q;
    if (level_d != '0) begin
      head_d = (w_wr && (wr_ptr_q == rd_ptr_d)) ? w_entry : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      fidx_q   <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      fidx_q   <= fidx_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= w_entry;
    end
  end

  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign level     = level_q;
  assign {out_l, out_r, out_b, out_c, out_pl, out_pr} = head_q;

endmodule

`default_nettype wire
